// File: rtl/sys_result_drain.sv
// Result-drain stage: buffers completed systolic-array tiles in a small FIFO and
// serializes them into MIG-width beats under a valid/ready handshake.
module sys_result_drain #(
    parameter int DATA_PRECISION = 16,
    parameter int SYS_ARR_SIZE   = 2,
    parameter int MIG_DATA_WIDTH = 32,
    parameter int TILE_DEPTH     = 2
) (
    input  logic                                             clk_i,
    input  logic                                             reset_n,
    input  logic [SYS_ARR_SIZE*SYS_ARR_SIZE*DATA_PRECISION-1:0] tile_i,
    input  logic                                             tile_valid_i,
    output logic                                             tile_ready_o,
    input  logic                                             clear_i,
    output logic [MIG_DATA_WIDTH-1:0]                        beat_data_o,
    output logic                                             beat_valid_o,
    input  logic                                             beat_ready_i,
    output logic                                             beat_last_o,
    output logic [15:0]                                      tiles_done_o,
    output logic                                             overflow_o
);

    localparam int EPB    = MIG_DATA_WIDTH / DATA_PRECISION;
    localparam int ELEMS  = SYS_ARR_SIZE * SYS_ARR_SIZE;
    localparam int BEATS  = ELEMS / EPB;
    localparam int TILE_W = ELEMS * DATA_PRECISION;
    localparam int PTR_W  = $clog2(TILE_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [TILE_W-1:0]         mem [TILE_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          count;
    logic [BIDX_W-1:0]         beat_idx;
    logic [15:0]               tiles_done;
    logic                      overflow;

    logic                      push;
    logic                      drop;
    logic                      xfer;
    logic                      last_beat;
    logic                      pop;
    logic [TILE_W-1:0]         head;
    logic [MIG_DATA_WIDTH-1:0] head_beats [BEATS];

    // Handshake qualifiers depend only on registered state, so beat_ready_i
    // never reaches tile_ready_o combinationally.
    assign tile_ready_o = (count != CNT_W'(TILE_DEPTH));
    assign beat_valid_o = (count != '0);
    assign push         = tile_valid_i & tile_ready_o;
    assign drop         = tile_valid_i & ~tile_ready_o;
    assign last_beat    = (beat_idx == BIDX_W'(BEATS - 1));
    assign xfer         = beat_valid_o & beat_ready_i;
    assign pop          = xfer & last_beat;

    assign head = mem[rd_ptr];

    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        assign head_beats[b] = head[b*MIG_DATA_WIDTH +: MIG_DATA_WIDTH];
    end

    assign beat_data_o  = beat_valid_o ? head_beats[beat_idx] : '0;
    assign beat_last_o  = beat_valid_o & last_beat;
    assign tiles_done_o = tiles_done;
    assign overflow_o   = overflow;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            beat_idx   <= '0;
            tiles_done <= '0;
            overflow   <= 1'b0;
            for (int i = 0; i < TILE_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            beat_idx   <= '0;
            tiles_done <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= tile_i;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (xfer) begin
                if (last_beat) begin
                    beat_idx   <= '0;
                    rd_ptr     <= rd_ptr + 1'b1;
                    tiles_done <= tiles_done + 16'd1;
                end else begin
                    beat_idx <= beat_idx + 1'b1;
                end
            end
            // A push and a pop in the same cycle leave occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
